// File: rtl/counting_pkg.sv
// Definitions shared by the num symbol generator and the counting sequence detector.
package counting_pkg;

   localparam int SYM_W = 2;
   localparam logic [SYM_W-1:0] IDLE_SYM = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/num_pattern_ram.sv
// Pattern store for num_seq_gen: synchronous write, asynchronous read, cleared on reset.
module num_pattern_ram
   import counting_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [SYM_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [SYM_W-1:0] rd_data
);

   logic [SYM_W-1:0] mem_q [DEPTH];
   logic [SYM_W-1:0] mem_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rst_n) begin
            mem_q[i] <= IDLE_SYM;
         end else begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/num_seq_gen.sv
// Replays a stored symbol pattern onto the num stream and counts detector ans pulses.
module num_seq_gen
   import counting_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8,
   parameter int HOLD_W = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [SYM_W-1:0]  wr_data,
   input  logic [AW:0]       len,
   input  logic [CNT_W-1:0]  reps,
   input  logic [HOLD_W-1:0] hold,
   input  logic              start,
   input  logic              abort,
   input  logic              ans_in,
   output logic [SYM_W-1:0]  num,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  hit_cnt
);

   localparam logic [AW:0]       LEN_MAX  = (AW+1)'(DEPTH);
   localparam logic [AW:0]       LEN_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]     IDX_ONE  = AW'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   state_t            state_q, state_d;
   logic [AW:0]       len_q, len_d;
   logic [CNT_W-1:0]  reps_q, reps_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [AW-1:0]     sym_idx_q, sym_idx_d;
   logic [CNT_W-1:0]  rep_idx_q, rep_idx_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [SYM_W-1:0]  num_q, num_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              start_ok;
   logic              ram_wr;
   logic              last_hold;
   logic              last_sym;
   logic              last_rep;
   logic [SYM_W-1:0]  rd_data;

   // The RAM is read at the next index so num can be registered without a bubble.
   num_pattern_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ram_wr),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (sym_idx_d),
      .rd_data (rd_data)
   );

   always_comb begin
      start_ok  = start && (len != '0) && (len <= LEN_MAX);
      ram_wr    = wr_en && (state_q == ST_IDLE) && !start_ok;
      last_hold = (hold_cnt_q == hold_q);
      last_sym  = ({1'b0, sym_idx_q} == (len_q - LEN_ONE));
      last_rep  = (rep_idx_q == (reps_q - CNT_ONE));

      state_d    = state_q;
      len_d      = len_q;
      reps_d     = reps_q;
      hold_d     = hold_q;
      sym_idx_d  = sym_idx_q;
      rep_idx_d  = rep_idx_q;
      hold_cnt_d = hold_cnt_q;
      hit_cnt_d  = hit_cnt_q;

      if ((state_q != ST_IDLE) && ans_in && (hit_cnt_q != '1)) begin
         hit_cnt_d = hit_cnt_q + CNT_ONE;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               len_d      = len;
               reps_d     = (reps == '0) ? CNT_ONE : reps;
               hold_d     = hold;
               sym_idx_d  = '0;
               rep_idx_d  = '0;
               hold_cnt_d = '0;
               hit_cnt_d  = '0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!last_hold) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end else begin
               hold_cnt_d = '0;
               if (!last_sym) begin
                  sym_idx_d = sym_idx_q + IDX_ONE;
               end else begin
                  sym_idx_d = '0;
                  if (last_rep) begin
                     state_d = ST_DONE;
                  end else begin
                     rep_idx_d = rep_idx_q + CNT_ONE;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the next state so they are all registered alongside it.
      valid_d = (state_d == ST_RUN);
      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
      num_d   = (state_d == ST_RUN) ? rd_data : IDLE_SYM;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         reps_q     <= '0;
         hold_q     <= '0;
         sym_idx_q  <= '0;
         rep_idx_q  <= '0;
         hold_cnt_q <= '0;
         hit_cnt_q  <= '0;
         num_q      <= IDLE_SYM;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         reps_q     <= reps_d;
         hold_q     <= hold_d;
         sym_idx_q  <= sym_idx_d;
         rep_idx_q  <= rep_idx_d;
         hold_cnt_q <= hold_cnt_d;
         hit_cnt_q  <= hit_cnt_d;
         num_q      <= num_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign num     = num_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_num_seq_gen.sv
// Randomized bench for num_seq_gen against a queue-based replay model of the pattern stream.
module tb_num_seq_gen;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [1:0] wr_data;
   logic [4:0] len;
   logic [7:0] reps;
   logic [3:0] hold;
   logic       start;
   logic       abort;
   logic       ans_in;

   logic [1:0] num, num_s;
   logic       valid, valid_s, busy, busy_s, done, done_s;
   logic [7:0] hit_cnt;
   logic [2:0] hit_sat;

   int checks = 0;
   int errors = 0;
   logic [1:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   num_seq_gen dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .reps(reps), .hold(hold), .start(start), .abort(abort), .ans_in(ans_in),
      .num(num), .valid(valid), .busy(busy), .done(done), .hit_cnt(hit_cnt)
   );

   // Narrow-counter instance used to observe saturation.
   num_seq_gen #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .reps(reps[2:0]), .hold(hold), .start(start), .abort(abort), .ans_in(ans_in),
      .num(num_s), .valid(valid_s), .busy(busy_s), .done(done_s), .hit_cnt(hit_sat)
   );

   function automatic int sat(input int n, input int w);
      int m;
      m = (1 << w) - 1;
      return (n > m) ? m : n;
   endfunction

   function automatic logic ans_bit(input int mode, input int i);
      case (mode)
         1:       return 1'($urandom_range(0, 1));
         2:       return 1'b1;
         3:       return (i < 5);
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input int addr, input logic [1:0] data);
      wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
      tick();
      wr_en = 1'b0;
      model_mem[addr] = data;
   endtask

   task automatic load_random(input int n);
      for (int a = 0; a < n; a++) write_mem(a, 2'($urandom_range(0, 3)));
   endtask

   // disturb: 1 = start pulse mid-run, 2 = writes during run, 3 = write together with start
   task automatic do_run(input int l, input int r, input int h, input int ans_mode, input int disturb);
      logic [1:0] q[$];
      int eff_reps, hits;
      logic [4:0] obs, expv;
      eff_reps = (r == 0) ? 1 : r;
      q = {};
      for (int p = 0; p < eff_reps; p++)
         for (int s = 0; s < l; s++)
            for (int k = 0; k <= h; k++) q.push_back(model_mem[s]);
      len = 5'(l); reps = 8'(r); hold = 4'(h); start = 1'b1;
      if (disturb == 3) begin
         wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~model_mem[0];
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
      hits = 0;
      checks++;
      if (hit_cnt !== 8'd0) begin
         errors++; $display("[TB] FAIL hit_clear: got %0d expected 0", hit_cnt);
      end
      for (int i = 0; i < q.size(); i++) begin
         obs  = {num, valid, busy, done};
         expv = {q[i], 3'b110};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL replay[%0d] len=%0d reps=%0d hold=%0d: got %b expected %b", i, l, r, h, obs, expv);
         end
         ans_in = ans_bit(ans_mode, i);
         if (ans_in) hits++;
         start = (disturb == 1 && i == 1);
         if (start) len = 5'd1;
         if (disturb == 2) begin
            wr_en = 1'b1; wr_addr = 4'(i % DEPTH); wr_data = 2'($urandom_range(0, 3));
         end
         tick();
      end
      start = 1'b0; wr_en = 1'b0;
      obs = {num, valid, busy, done};
      checks++;
      if (obs !== 5'b00001) begin
         errors++; $display("[TB] FAIL done_cycle: got %b expected 00001", obs);
      end
      ans_in = (ans_mode == 1) ? 1'($urandom_range(0, 1)) : (ans_mode == 2 || ans_mode == 3);
      if (ans_in) hits++;
      tick();
      ans_in = 1'b0;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++; $display("[TB] FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
      end
      checks++;
      if (hit_cnt !== 8'(sat(hits, 8)) || hit_sat !== 3'(sat(hits, 3))) begin
         errors++;
         $display("[TB] FAIL hit_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, hit_sat, sat(hits, 8), sat(hits, 3));
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({num, valid, busy, done} !== 5'b0) begin
         errors++; $display("[TB] FAIL %s: got %b expected 00000", name, {num, valid, busy, done});
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; reps = '0;
      hold = '0; start = 1'b0; abort = 1'b0; ans_in = 1'b0;
      tick(); tick();
      check_idle("reset_outputs");
      checks++;
      if (hit_cnt !== 8'd0 || hit_sat !== 3'd0) begin
         errors++; $display("[TB] FAIL reset_hit: got %0d expected 0", hit_cnt);
      end
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = 2'b00;
      tick();
   endtask

   task automatic test_basic_replay;
      logic [1:0] pat [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
      for (int a = 0; a < 7; a++) write_mem(a, pat[a]);
      do_run(7, 1, 0, 0, 0);
   endtask

   task automatic test_hold_repeat;
      write_mem(0, 2'd1);
      write_mem(1, 2'd2);
      do_run(2, 3, 2, 0, 0);
      do_run(2, 0, 1, 0, 0);
   endtask

   task automatic test_hit_count;
      load_random(DEPTH);
      do_run(7, 1, 0, 3, 0);
      do_run(9, 1, 0, 2, 0);
      do_run(3, 1, 0, 0, 0);
   endtask

   task automatic test_abort;
      load_random(7);
      len = 5'd7; reps = 8'd1; hold = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (num !== model_mem[i] || valid !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_pre[%0d]: got %b/%b expected %b/1", i, num, valid, model_mem[i]);
         end
         ans_in = (i < 2);
         abort = (i == 2);
         tick();
      end
      abort = 1'b0; ans_in = 1'b0;
      check_idle("abort_idle");
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (hit_cnt !== 8'd2 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_hold[%0d]: got hit=%0d done=%b expected 2 0", i, hit_cnt, done);
         end
         tick();
      end
      len = 5'd5; hold = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check_idle("abort_start");
      tick();
      check_idle("abort_start_stay");
   endtask

   task automatic test_illegal;
      len = 5'd0; reps = 8'd1; hold = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check_idle("len0_ignored");
      len = 5'd17; start = 1'b1;
      tick();
      start = 1'b0;
      check_idle("len17_ignored");
      load_random(6);
      do_run(6, 1, 1, 0, 1);
      do_run(6, 2, 0, 0, 2);
      do_run(6, 1, 0, 0, 0);
      do_run(1, 1, 0, 0, 3);
      do_run(2, 1, 0, 0, 0);
   endtask

   task automatic test_reset_mid_run;
      load_random(DEPTH);
      do_run(16, 2, 1, 1, 0);
      len = 5'd16; reps = 8'd1; hold = 4'd0; start = 1'b1;
      tick();
      start = 1'b0; ans_in = 1'b1;
      tick(); tick();
      rst_n = 1'b0; ans_in = 1'b0;
      tick();
      check_idle("reset_mid_run");
      checks++;
      if (hit_cnt !== 8'd0) begin
         errors++; $display("[TB] FAIL reset_mid_hit: got %0d expected 0", hit_cnt);
      end
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = 2'b00;
      tick();
      do_run(16, 1, 0, 0, 0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 8; n++) begin
         load_random(DEPTH);
         do_run($urandom_range(1, 16), $urandom_range(0, 3), $urandom_range(0, 3), 1, 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_replay();
      test_hold_repeat();
      test_hit_count();
      test_abort();
      test_illegal();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/num_seq_gen.md
# num_seq_gen

Pattern-driven transmitter for the 2-bit `num` symbol stream consumed by the `counting` sequence detector. Software-visible logic loads a pattern of up to `DEPTH` symbols, then issues `start`. The block replays the pattern one symbol per `HOLD+1` cycles, for `reps` repetitions. It also counts the detector's `ans` pulses during the run, so a detector can be exercised in-system without a testbench driving `num` by hand.

## Interface
Parameters:
- `DEPTH`, 16: pattern memory entries (power of two, ≥2); `AW = $clog2(DEPTH)`.
- `CNT_W`, 8: width of `reps` and `hit_cnt`.
- `HOLD_W`, 4: width of `hold`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write `wr_data` to `mem[wr_addr]`.
- `wr_addr`  in  AW  pattern write address.
- `wr_data`  in  2  pattern symbol.
- `len`  in  AW+1  symbols per pass, 1..DEPTH; sampled on accepted `start`.
- `reps`  in  CNT_W  passes; sampled on accepted `start`; 0 treated as 1.
- `hold`  in  HOLD_W  extra cycles each symbol is held; sampled on accepted `start`.
- `start`  in  1  begin run (pulse).
- `abort`  in  1  terminate run.
- `ans_in`  in  1  detector `ans` output.
- `num`  out  2  symbol stream to detector.
- `valid`  out  1  `num` carries a pattern symbol.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse, run completed normally.
- `hit_cnt`  out  CNT_W  saturating count of `ans_in` high cycles in the last run.

## Operation
- **Reset** (`rst_n`=0 at edge):
  - State → IDLE.
  - `num`=2'b00, `valid`=0, `busy`=0, `done`=0, `hit_cnt`=0.
  - All `mem` entries cleared to 2'b00.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `wr_en` writes memory.
  - `start` is accepted only if `len` is in 1..DEPTH; otherwise it is ignored and the state stays IDLE.
  - On an accepted `start`:
    - Latch `len`, `reps` (0→1) and `hold`.
    - Clear `hit_cnt`, `sym_idx`, `rep_idx` and `hold_cnt`.
    - Go to RUN.
  - `wr_en` in the same cycle as an accepted `start` is dropped.
- **RUN:**
  - `num`=`mem[sym_idx]`, `valid`=1, `busy`=1.
  - `hold_cnt` counts 0..hold; on reaching `hold`, advance `sym_idx`.
  - `sym_idx` wraps from `len`-1 to 0 and increments `rep_idx`.
  - After the final symbol of pass `reps`, go to DONE.
  - `wr_en` is ignored (memory frozen).
  - A `start` in RUN is ignored.
- **DONE (one cycle):**
  - `done`=1, `busy`=0, `valid`=0, `num`=2'b00.
  - Next state is IDLE.
- **abort:**
  - Effective in RUN or DONE; has priority over `start` and over the advance logic.
  - Next cycle: IDLE, `valid`=0, `num`=0, no `done` pulse.
  - `hit_cnt` holds its value.
- **hit_cnt:**
  - Increments on every edge where `ans_in`=1 and the state is RUN or DONE. The DONE cycle captures the detector's registered response to the last symbol.
  - Saturates at 2^CNT_W−1.
  - Holds its value in IDLE until the next accepted `start`.
- **Arithmetic:** all index/counter compares are unsigned. `len`=DEPTH requires the AW+1-bit compare, and no index overflow is permitted.

## Timing
- **Start to first symbol:** `start` accepted at edge t; `num`=`mem[0]` and `valid`=1 from t+1.
- **Symbol duration:** each symbol is driven for exactly `hold`+1 cycles, and consecutive symbols are gapless, including across pass boundaries.
- **Run length:** RUN lasts `len`×(`hold`+1)×`reps` cycles. `done` is asserted in the following cycle, and `busy` falls in the same cycle `done` rises.
- **Outputs:** `num`, `valid`, `busy` and `done` are registered (no combinational path from inputs).
- **Reset mid-run:** outputs are at reset values one edge after `rst_n`=0. `rst_n` dominates `abort`, and `abort` dominates `start`.

## Structure
- Shared package `counting_pkg` contains:
  - `SYM_W`=2.
  - `IDLE_SYM`=2'b00.
  - FSM state encoding (IDLE, RUN, DONE).
  - Shared with the `counting` detector.
- Sub-module `num_pattern_ram`:
  - DEPTH×2 register array, synchronous write, asynchronous read, synchronous clear on reset.
  - The top-level block holds the FSM, counters and hit counter.

## Test plan
- **Basic replay:** write pattern 0,1,2,3,3,2,1; `len`=7, `reps`=1, `hold`=0; pulse `start`.
  - Required: `num` = 0,1,2,3,3,2,1 on cycles t+1..t+7.
  - Required: `done` at t+8, `busy` low at t+8.
- **Hold and repeat:** `len`=2 (pattern 1,2), `reps`=3, `hold`=2.
  - Required: `num` = 1,1,1,2,2,2 repeated three times (18 cycles), then `done`.
  - Required: `reps`=0 behaves as 1.
- **Hit counting:** drive `ans_in`=1 on 5 RUN cycles and on the DONE cycle → `hit_cnt`=6.
  - With `CNT_W`=3 and 10 hits → `hit_cnt`=7 (saturated).
  - The next `start` clears `hit_cnt` to 0.
- **Abort:** `abort` at the 3rd symbol → IDLE next cycle, `valid`=0, no `done`, `hit_cnt` retained.
  - `abort`+`start` in the same cycle in RUN → IDLE.
- **Illegal/conflicting requests:**
  - `start` with `len`=0 or `len`=DEPTH+1 → ignored.
  - `start` while busy → ignored.
  - `wr_en` during RUN → memory unchanged (verify in the next run).
  - `wr_en`+`start` in the same cycle → write dropped.
- **Reset mid-run:** `rst_n`=0 during RUN → all outputs 0 next edge.
  - Memory reads 0 afterwards (a replay emits all 2'b00).
  - Boundary `len`=DEPTH replays all 16 entries.
